// File: rtl/stream_checker.sv
// -----------------------------------------------------------------------------
// stream_checker
//
// Receive end of the 32-bit incrementing test-word stream. The generator
// emits a word/strobe pair per word. The pair then passes through the SDRAM
// write/read path before it reaches this block. Each accepted word must equal
// the previous word + 1 (mod 2^32). The block counts words and mismatches,
// captures the first mismatch, and raises a sticky flag when the stream
// stalls. The results drive board LEDs and the debug readout.
//
// Optional feature (compile-time macro STREAM_CHECKER_RESYNC_EN):
//   defined   : after a mismatch the reference resyncs to the received word
//               (exp <= s32 + 1). A single corrupted word costs two errors;
//               a dropped word costs one.
//   undefined : the reference always advances by one (exp <= exp + 1). Errors
//               are positional, so a dropped word makes every later word
//               mismatch.
//
// Parameters:
//   SEED      : expected first word when USE_SEED = 1
//   USE_SEED  : 1 = first word is checked against SEED,
//               0 = first word is adopted unchecked
//   ERR_CNT_W : width of the saturating mismatch counter
//   GAP_LIMIT : idle cycles tolerated between strobes while checking (>= 2)
//   GAP_W     : gap counter width, 2^GAP_W must exceed GAP_LIMIT
//
// Ports:
//   clk       in   system clock
//   n_rst     in   asynchronous active-low reset
//   en        in   checker enable
//   clr       in   synchronous clear of counters and sticky flags
//   s32       in   received stream word
//   n32rdy    in   word strobe, one cycle per word
//   locked    out  first word accepted, checking active
//   err_pulse out  one-cycle pulse per mismatched word
//   err       out  sticky mismatch flag
//   err_cnt   out  saturating mismatch count
//   word_cnt  out  words accepted since lock (wraps)
//   timeout   out  sticky stall flag
//   bad_got   out  first mismatched word received
//   bad_exp   out  value expected at the first mismatch
// -----------------------------------------------------------------------------
module stream_checker #(
  parameter logic [31:0] SEED      = 32'hFAFBFCFD,
  parameter bit          USE_SEED  = 1'b1,
  parameter int          ERR_CNT_W = 16,
  parameter int          GAP_LIMIT = 64,
  parameter int          GAP_W     = 7
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [31:0]          s32,
  input  logic                 n32rdy,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [31:0]          word_cnt,
  output logic                 timeout,
  output logic [31:0]          bad_got,
  output logic [31:0]          bad_exp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_LIMIT);
  localparam logic [GAP_W-1:0] GAP_PRE = GAP_W'(GAP_LIMIT - 1);

  // Saturating increment: the count sticks at all-ones, so a long-running
  // error burst never wraps back to a small value on the readout.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        exp;
  logic [31:0]        exp_nxt;
  logic [31:0]        ref_word;
  logic [GAP_W-1:0]   gap;
  logic               accept;
  logic               accept_act;
  logic               mismatch;
  logic               gap_run;

  // ---------------------------------------------------------------------------
  // Next-state and word-compare logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    exp_nxt    = exp;
    mismatch   = 1'b0;
    accept     = en & n32rdy;
    accept_act = 1'b0;
    gap_run    = 1'b0;
    // In SYNC the reference is SEED. The exp register only becomes
    // meaningful once the first word has been taken.
    ref_word   = (state == SYNC) ? SEED : exp;

    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = SYNC;
        end
      end
      SYNC: begin
        if (accept) begin
          accept_act = 1'b1;
          mismatch   = USE_SEED && (s32 != SEED);
          // On a bad first word, continue from SEED rather than from the bad word.
          exp_nxt    = mismatch ? (SEED + 32'd1) : (s32 + 32'd1);
          state_nxt  = CHECK;
        end
      end
      CHECK: begin
        if (accept) begin
          accept_act = 1'b1;
          mismatch   = (s32 != exp);
`ifdef STREAM_CHECKER_RESYNC_EN
          exp_nxt    = s32 + 32'd1;
`else
          exp_nxt    = exp + 32'd1;
`endif
        end else if (en) begin
          gap_run = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Dropping enable returns to IDLE from anywhere. Counters and sticky
    // flags are held, and the next enable reseeds through SYNC.
    if (!en) begin
      state_nxt = IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference, counters, flags and capture registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      exp       <= SEED;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      word_cnt  <= '0;
      timeout   <= 1'b0;
      bad_got   <= '0;
      bad_exp   <= '0;
      gap       <= '0;
    end else begin
      exp       <= exp_nxt;
      locked    <= (state_nxt == CHECK);
      // The pulse reports the mismatch even when clr wipes the counters on
      // the same edge.
      err_pulse <= mismatch;

      if (clr) begin
        err      <= 1'b0;
        err_cnt  <= '0;
        timeout  <= 1'b0;
        bad_got  <= '0;
        bad_exp  <= '0;
        word_cnt <= '0;
        gap      <= '0;
      end else begin
        if (mismatch) begin
          err     <= 1'b1;
          err_cnt <= sat_inc(err_cnt);
          // Only the first mismatch since the last clear is captured.
          if (!err) begin
            bad_got <= s32;
            bad_exp <= ref_word;
          end
        end

        if (accept_act) begin
          word_cnt <= (state == SYNC) ? 32'd1 : (word_cnt + 32'd1);
        end

        // The gap counts idle CHECK cycles. It stops at GAP_LIMIT, and
        // timeout rises on the edge that takes it there.
        if (accept_act) begin
          gap <= '0;
        end else if (gap_run && (gap != GAP_MAX)) begin
          gap <= gap + GAP_W'(1);
          if (gap == GAP_PRE) begin
            timeout <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_stream_checker
//
// Bench for stream_checker. Instance u_dut uses the default parameters and is
// compared every cycle against a word-level reference model. Instance u_wrap
// uses SEED = FFFFFFFE and a 4-bit error counter. It covers the wrap-around
// stream and counter saturation.
// -----------------------------------------------------------------------------
module tb_stream_checker;

  localparam logic [31:0] SEED      = 32'hFAFBFCFD;
  localparam int          GAP_LIMIT = 64;
  localparam int          ERR_MAX   = 65535;
`ifdef STREAM_CHECKER_RESYNC_EN
  localparam int          T2_ERRS   = 2;
`else
  localparam int          T2_ERRS   = 1;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        en = 1'b0, clr = 1'b0, rdy = 1'b0;
  logic [31:0] s32 = '0;
  logic        locked, err_pulse, err, timeout;
  logic [15:0] err_cnt;
  logic [31:0] word_cnt, bad_got, bad_exp;

  logic        en_b = 1'b0, clr_b = 1'b0, rdy_b = 1'b0;
  logic [31:0] s_b = '0;
  logic        b_locked, b_err_pulse, b_err, b_timeout;
  logic [3:0]  b_err_cnt;
  logic [31:0] b_word_cnt, b_bad_got, b_bad_exp;

  stream_checker u_dut (
    .clk(clk), .n_rst(n_rst), .en(en), .clr(clr), .s32(s32), .n32rdy(rdy),
    .locked(locked), .err_pulse(err_pulse), .err(err), .err_cnt(err_cnt),
    .word_cnt(word_cnt), .timeout(timeout), .bad_got(bad_got), .bad_exp(bad_exp)
  );

  stream_checker #(.SEED(32'hFFFFFFFE), .ERR_CNT_W(4)) u_wrap (
    .clk(clk), .n_rst(n_rst), .en(en_b), .clr(clr_b), .s32(s_b), .n32rdy(rdy_b),
    .locked(b_locked), .err_pulse(b_err_pulse), .err(b_err), .err_cnt(b_err_cnt),
    .word_cnt(b_word_cnt), .timeout(b_timeout), .bad_got(b_bad_got), .bad_exp(b_bad_exp)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, want);
  endtask

  // Reference model: tracks the enable phase, the word the stream should
  // carry next, and the status a checker should report.
  int          m_phase;    // 0 disabled, 1 waiting for first word, 2 checking
  logic [31:0] m_next;
  logic [31:0] m_words, m_bgot, m_bexp;
  int          m_errs, m_idle;
  bit          m_locked, m_pulse, m_err, m_to;

  task automatic model_reset();
    m_phase = 0; m_next = SEED; m_words = 0; m_bgot = 0; m_bexp = 0;
    m_errs = 0; m_idle = 0; m_locked = 0; m_pulse = 0; m_err = 0; m_to = 0;
  endtask

  task automatic model_edge();
    logic [31:0] want;
    bit          bad;
    bit          take;
    take    = en && rdy && (m_phase != 0);
    m_pulse = 0;
    if (take) begin
      want = (m_phase == 1) ? SEED : m_next;
      bad  = (s32 != want);
`ifdef STREAM_CHECKER_RESYNC_EN
      m_next = (bad && m_phase == 1) ? SEED + 1 : s32 + 1;
`else
      m_next = (m_phase == 1 && !bad) ? s32 + 1 : want + 1;
`endif
      m_words = (m_phase == 1) ? 32'd1 : m_words + 1;
      m_idle  = 0;
      if (bad) begin
        m_pulse = 1;
        if (!m_err) begin m_bgot = s32; m_bexp = want; end
        m_err = 1;
        if (m_errs < ERR_MAX) m_errs++;
      end
    end else if (m_phase == 2 && en) begin
      if (m_idle < GAP_LIMIT) m_idle++;
      if (m_idle >= GAP_LIMIT) m_to = 1;
    end
    if (clr) begin
      m_err = 0; m_errs = 0; m_to = 0; m_bgot = 0; m_bexp = 0; m_words = 0; m_idle = 0;
    end
    if (!en) m_phase = 0;
    else if (m_phase == 0) m_phase = 1;
    else if (m_phase == 1 && take) m_phase = 2;
    m_locked = (m_phase == 2);
  endtask

  task automatic compare_all();
    check("locked",    32'(locked),    32'(m_locked));
    check("err_pulse", 32'(err_pulse), 32'(m_pulse));
    check("err",       32'(err),       32'(m_err));
    check("err_cnt",   32'(err_cnt),   m_errs);
    check("word_cnt",  word_cnt,       m_words);
    check("timeout",   32'(timeout),   32'(m_to));
    check("bad_got",   bad_got,        m_bgot);
    check("bad_exp",   bad_exp,        m_bexp);
  endtask

  task automatic step();
    @(posedge clk);
    if (n_rst) model_edge();
    #1;
    compare_all();
  endtask

  task automatic send(input logic [31:0] w, input int idle);
    rdy = 1'b1; s32 = w;
    step();
    rdy = 1'b0;
    repeat (idle) step();
  endtask

  initial begin
    logic [31:0] gen, w;
    int          r, r2, idle;

    model_reset();
    #12;
    check("rst_locked",   32'(locked), 0);
    check("rst_word_cnt", word_cnt,    0);
    check("rst_err_cnt",  32'(err_cnt), 0);
    check("rst_bad_exp",  bad_exp,     0);
    check("rst_b_wcnt",   b_word_cnt,  0);
    @(negedge clk) n_rst = 1'b1;
    en = 1'b1;
    step(); step();

    // Clean stream, one strobe every 12 cycles.
    for (int i = 0; i < 1000; i++) begin
      send(SEED + i, 11);
      if (i == 0) check("t1_lock_first", 32'(locked), 1);
    end
    check("t1_word_cnt", word_cnt, 1000);
    check("t1_err_cnt",  32'(err_cnt), 0);
    check("t1_timeout",  32'(timeout), 0);
    check("t1_locked",   32'(locked), 1);

    // Reseed, then corrupt the fifth word.
    en = 1'b0; clr = 1'b1; step(); clr = 1'b0; en = 1'b1; step();
    for (int i = 0; i < 12; i++) begin
      send((i == 4) ? 32'h0 : SEED + i, 0);
      if (i == 4) check("t2_pulse_w5", 32'(err_pulse), 1);
      repeat (11) step();
    end
    check("t2_bad_got", bad_got, 32'h00000000);
    check("t2_bad_exp", bad_exp, 32'hFAFBFD01);
    check("t2_err_cnt", 32'(err_cnt), T2_ERRS);

    // Wrap-around stream back-to-back, then drive the 4-bit counter to saturation.
    en_b = 1'b1; step(); step();
    for (int i = 0; i < 4; i++) begin
      rdy_b = 1'b1; s_b = 32'hFFFFFFFE + i; step();
    end
    rdy_b = 1'b0; step();
    check("t3_err_cnt",  32'(b_err_cnt), 0);
    check("t3_word_cnt", b_word_cnt, 4);
    check("t3_err",      32'(b_err), 0);
    for (int i = 0; i < 20; i++) begin
      rdy_b = 1'b1; s_b = 32'h12345678; step();
      if (i == 13) check("t5_err_cnt_14", 32'(b_err_cnt), 32'hE);
    end
    rdy_b = 1'b0; step();
    check("t5_err_cnt_sat", 32'(b_err_cnt), 32'hF);
    check("t5_bad_got",     b_bad_got, 32'h12345678);
    check("t5_bad_exp",     b_bad_exp, 32'h00000002);

    // Stall detection and clear.
    en = 1'b0; clr = 1'b1; step(); clr = 1'b0; en = 1'b1; step();
    send(SEED, 0);
    repeat (GAP_LIMIT - 1) step();
    check("t4_timeout_early", 32'(timeout), 0);
    step();
    check("t4_timeout_at_limit", 32'(timeout), 1);
    clr = 1'b1; step(); clr = 1'b0;
    check("t4_timeout_clr", 32'(timeout), 0);
    check("t4_locked_clr",  32'(locked), 1);

    // Randomized traffic: corruption, drops, stalls, clears, enable toggles.
    gen = SEED + 1;
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        en = 1'b0; step(); en = 1'b1; step();
        gen = ($urandom_range(0, 1) != 0) ? SEED : $urandom;
      end else if (r < 4) begin
        clr = 1'b1;
      end
      w = gen; gen = gen + 1;
      r2 = $urandom_range(0, 99);
      if (r2 < 3) w = $urandom;
      else if (r2 < 6) begin w = gen; gen = gen + 1; end
      rdy = 1'b1; s32 = w; step(); clr = 1'b0; rdy = 1'b0;
      idle = ($urandom_range(0, 99) < 3) ? $urandom_range(60, 70) : $urandom_range(0, 4);
      repeat (idle) step();
    end

    // Asynchronous reset mid-stream.
    rdy = 1'b1; s32 = gen; step();
    #2 n_rst = 1'b0;
    #1;
    check("t6_locked",   32'(locked),  0);
    check("t6_err",      32'(err),     0);
    check("t6_err_cnt",  32'(err_cnt), 0);
    check("t6_word_cnt", word_cnt,     0);
    check("t6_timeout",  32'(timeout), 0);
    check("t6_bad_got",  bad_got,      0);
    check("t6_b_err",    32'(b_err),   0);
    model_reset();
    rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
    step();
    for (int i = 0; i < 10; i++) send(SEED + i, 1);
    check("t6_after_err",  32'(err), 0);
    check("t6_after_wcnt", word_cnt, 10);
    check("t6_after_lock", 32'(locked), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
